// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter using the inhibit / request-to-send
// handshake, device-clocked data bits and a final ACK check.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int RTS_CYCLES     = 2000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + INHIBIT_CYCLES + RTS_CYCLES + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);
    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_DATA, S_ACK, S_WAIT_REL, S_DONE, S_ERR
    } state_t;
    state_t        r_state;
    logic [1:0]    r_clk_sync;
    logic [1:0]    r_data_sync;
    logic          r_clk_filt;
    logic          r_clk_filt_d;
    logic [FW-1:0] r_filt_cnt;
    logic [CW-1:0] r_cnt;
    logic [10:0]   r_shift;
    logic [3:0]    r_bitcnt;
    logic          r_done;
    logic          r_err;
    logic          r_clk_oe;
    logic          r_data_oe;
    logic          w_clk;
    logic          w_data;
    logic          w_fall;
    assign w_clk       = r_clk_sync[1];
    assign w_data      = r_data_sync[1];
    assign w_fall      = r_clk_filt_d & ~r_clk_filt;
    assign tx_ready    = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign tx_done     = r_done;
    assign tx_err      = r_err;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    // Synchronisers start high (idle bus) so reset release never produces a spurious fall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clk_sync   <= 2'b11;
            r_data_sync  <= 2'b11;
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
            r_filt_cnt   <= '0;
        end else begin
            r_clk_sync   <= {r_clk_sync[0], ps2_clk_in};
            r_data_sync  <= {r_data_sync[0], ps2_data_in};
            r_clk_filt_d <= r_clk_filt;
            if (w_clk == r_clk_filt) r_filt_cnt <= '0;
            else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                r_clk_filt <= w_clk;
                r_filt_cnt <= '0;
            end else r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: if (tx_valid) begin
                    r_shift  <= {1'b1, ~^tx_data, tx_data};
                    r_bitcnt <= '0;
                    r_cnt    <= '0;
                    r_clk_oe <= 1'b1;
                    r_state  <= S_INHIBIT;
                end
                S_INHIBIT: if (r_cnt == CW'(INHIBIT_CYCLES - 1)) begin
                    r_cnt     <= '0;
                    r_data_oe <= 1'b1;
                    r_state   <= S_RTS;
                end else r_cnt <= r_cnt + 1'b1;
                S_RTS: if (r_cnt == CW'(RTS_CYCLES - 1)) begin
                    r_cnt    <= '0;
                    r_clk_oe <= 1'b0;
                    r_state  <= S_DATA;
                end else r_cnt <= r_cnt + 1'b1;
                S_DATA, S_ACK, S_WAIT_REL: begin
                    r_cnt <= w_fall ? '0 : r_cnt + 1'b1;
                    // A device clock edge outranks a coincident timeout.
                    if (w_fall && r_state == S_DATA) begin
                        r_data_oe <= ~r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bitcnt  <= r_bitcnt + 1'b1;
                        if (r_bitcnt == 4'd9) r_state <= S_ACK;
                    end else if (w_fall && r_state == S_ACK) begin
                        r_err   <= w_data;
                        r_state <= w_data ? S_ERR : S_WAIT_REL;
                    end else if (r_state == S_WAIT_REL && w_clk && w_data) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (!w_fall && r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        r_err     <= 1'b1;
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_state   <= S_ERR;
                    end
                end
                S_DONE, S_ERR: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed and randomized frames against a PS/2 device model that clocks the bus,
// captures the bits it sees and chooses ACK or NACK.
module tb_ps2_host_tx;
    localparam int INH  = 20;
    localparam int RTS  = 10;
    localparam int TMO  = 300;
    localparam int HALF = 20;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe;
    logic       bfm_clk = 1'b1;
    logic       bfm_data = 1'b1;
    logic       ps2_clk_in, ps2_data_in;
    int         checks = 0;
    int         errors = 0;
    int         n_done = 0;
    int         n_err = 0;
    assign ps2_clk_in  = bfm_clk & ~ps2_clk_oe;
    assign ps2_data_in = bfm_data & ~ps2_data_oe;
    always #5 clk = ~clk;
    ps2_host_tx #(
        .INHIBIT_CYCLES(INH), .RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(8)
    ) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .tx_done(tx_done), .tx_err(tx_err),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );
    always @(negedge clk) if (tx_done || tx_err) begin
        if (tx_done) n_done++;
        if (tx_err) n_err++;
        checks++;
        assert (!(tx_done && tx_err)) else begin
            errors++;
            $error("FAIL done_err_exclusive observed=1 expected=0");
        end
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask
    // tx_valid stays high through the inhibit phase: a busy host must ignore it.
    task automatic start_frame(input logic [7:0] d);
        int n;
        tx_data  = d;
        tx_valid = 1'b1;
        cycles(1);
        chk("clk_oe_after_accept", ps2_clk_oe, 1);
        chk("busy_after_accept", busy, 1);
        n = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < 5000) begin n++; cycles(1); end
        tx_valid = 1'b0;
        chk("inhibit_len", n, INH);
        n = 0;
        while (ps2_clk_oe && ps2_data_oe && n < 5000) begin n++; cycles(1); end
        chk("rts_len", n, RTS);
        chk("start_bit_held", ps2_data_oe, 1);
    endtask
    task automatic pulse(output logic b, input logic glitch);
        bfm_clk = 1'b0;
        cycles(HALF);
        bfm_clk = 1'b1;
        b = ps2_data_in;
        chk("clk_oe_in_data", ps2_clk_oe, 0);
        if (glitch) begin
            cycles(5);
            bfm_clk = 1'b0;
            cycles(3);
            bfm_clk = 1'b1;
            cycles(HALF - 8);
        end else cycles(HALF);
    endtask
    task automatic frame(input logic [7:0] d, input logic ack, input logic glitch);
        logic [9:0] got, exp;
        logic       b, par;
        int         d0, e0, n;
        d0  = n_done;
        e0  = n_err;
        par = ($countones(d) % 2) == 0;
        exp = {1'b1, par, d};
        start_frame(d);
        cycles(25);
        for (int i = 0; i < 10; i++) begin
            pulse(b, glitch && i == 4);
            got[i] = b;
        end
        bfm_data = ack ? 1'b0 : 1'b1;
        pulse(b, 1'b0);
        bfm_data = 1'b1;
        n = 0;
        while (!tx_ready && n < 200) begin n++; cycles(1); end
        chk("frame_bits", got, exp);
        chk("done_pulses", n_done - d0, ack ? 1 : 0);
        chk("err_pulses", n_err - e0, ack ? 0 : 1);
        chk("ready_after_frame", tx_ready, 1);
        chk("clk_oe_after_frame", ps2_clk_oe, 0);
        chk("data_oe_after_frame", ps2_data_oe, 0);
    endtask
    initial begin
        logic b;
        int   n, d0, e0;
        cycles(3);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_err", tx_err, 0);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        reset = 1'b1;
        cycles(3);
        frame(8'hED, 1'b1, 1'b0);
        frame(8'hFF, 1'b0, 1'b0);
        frame(8'h3C, 1'b1, 1'b1);
        d0 = n_done;
        e0 = n_err;
        start_frame(8'h5A);
        n = 0;
        while (!tx_err && n < TMO + 100) begin n++; cycles(1); end
        chk("timeout_len", n, TMO);
        chk("timeout_clk_oe", ps2_clk_oe, 0);
        chk("timeout_data_oe", ps2_data_oe, 0);
        cycles(1);
        chk("timeout_ready", tx_ready, 1);
        chk("timeout_no_done", n_done - d0, 0);
        chk("timeout_one_err", n_err - e0, 1);
        for (int k = 0; k < 4; k++)
            frame(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        start_frame(8'h00);
        cycles(25);
        for (int i = 0; i < 3; i++) pulse(b, 1'b0);
        chk("pre_reset_data_oe", ps2_data_oe, 1);
        reset = 1'b0;
        #1;
        chk("async_rst_clk_oe", ps2_clk_oe, 0);
        chk("async_rst_data_oe", ps2_data_oe, 0);
        chk("async_rst_ready", tx_ready, 1);
        cycles(2);
        reset = 1'b1;
        cycles(50);
        chk("post_rst_ready", tx_ready, 1);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_clk_oe", ps2_clk_oe, 0);
        frame(8'hF4, 1'b1, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
